// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: one-hot FSM states,
// oversampling constants and the bit-decision helper.
package uart_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } rx_fsm_e;

  localparam int OS_RATE      = 16;
  localparam int SAMPLE_FIRST = 6;
  localparam int SAMPLE_LAST  = 10;
  localparam int FRAME_BITS   = 10;

  // Three or more ones out of five samples decide a logic 1.
  function automatic logic majority_5(input logic [2:0] ones);
    return (ones >= 3'd3);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous rs232_rx pin into the sys_clk domain and flags
// the high-to-low transition that marks a possible start bit.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic rs232_rx,
  output logic rx_sync,
  output logic fall_edge
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Two-stage synchroniser followed by the edge-history register; idle line is high.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rs232_rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign rx_sync   = sync2_r;
  assign fall_edge = ~sync2_r & prev_r;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 16x oversampling and 5-sample majority voting per
// bit; reports each good byte with rx_done and a bad stop bit with frame_err.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_state,
  output logic       frame_err
);

  localparam int OS_DIV = CLK_FREQ / (BAUD_RATE * OS_RATE);
  localparam int OS_W   = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OS_DIV - 1);
  localparam logic [7:0]      SLOT_LAST = 8'(FRAME_BITS * OS_RATE - 1);
  localparam logic [3:0]      PH_FIRST  = 4'(SAMPLE_FIRST);
  localparam logic [3:0]      PH_LAST   = 4'(SAMPLE_LAST);
  localparam logic [3:0]      LAST_DATA = 4'(FRAME_BITS - 2);

  logic            rx_sync_s;
  logic            fall_edge_s;
  rx_fsm_e         state_r;
  rx_fsm_e         state_s;
  logic [OS_W-1:0] os_cnt_r;
  logic [7:0]      slot_r;
  logic [2:0]      ones_r;
  logic [7:0]      shift_r;
  logic [7:0]      rx_data_r;
  logic            rx_done_r;
  logic            frame_err_r;
  logic            rx_state_r;
  logic            tick_s;
  logic [3:0]      phase_s;
  logic [3:0]      bit_idx_s;
  logic            in_window_s;
  logic            decide_s;
  logic [2:0]      ones_sum_s;
  logic            bit_val_s;
  logic            start_s;
  logic            done_s;
  logic            ferr_s;

  uart_rx_sync u_sync (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .rs232_rx  (rs232_rx),
    .rx_sync   (rx_sync_s),
    .fall_edge (fall_edge_s)
  );

  // Tick, slot position and the running majority sum for the current bit.
  always_comb begin
    tick_s      = (state_r != ST_IDLE) && (os_cnt_r == OS_LAST);
    phase_s     = slot_r[3:0];
    bit_idx_s   = slot_r[7:4];
    in_window_s = tick_s && (phase_s >= PH_FIRST) && (phase_s <= PH_LAST);
    decide_s    = tick_s && (phase_s == PH_LAST);
    ones_sum_s  = ones_r + {2'b00, rx_sync_s};
    bit_val_s   = majority_5(ones_sum_s);
    start_s     = (state_r == ST_IDLE) && fall_edge_s;
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and end-of-frame pulse decisions.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    ferr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        // A start bit that votes high was only a glitch; drop it silently.
        if (decide_s) begin
          state_s = bit_val_s ? ST_IDLE : ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (decide_s && (bit_idx_s == LAST_DATA)) begin
          state_s = ST_STOP;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (decide_s) begin
          state_s = ST_IDLE;
          done_s  = bit_val_s;
          ferr_s  = ~bit_val_s;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Oversample divider, slot counter and ones-count; restarted on each start edge.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      os_cnt_r <= '0;
      slot_r   <= 8'd0;
      ones_r   <= 3'd0;
    end else if (start_s || (state_r == ST_IDLE)) begin
      os_cnt_r <= '0;
      slot_r   <= 8'd0;
      ones_r   <= 3'd0;
    end else if (tick_s) begin
      os_cnt_r <= '0;
      slot_r   <= (slot_r == SLOT_LAST) ? 8'd0 : slot_r + 8'd1;
      if (decide_s) begin
        ones_r <= 3'd0;
      end else if (in_window_s) begin
        ones_r <= ones_sum_s;
      end else begin
        ones_r <= ones_r;
      end
    end else begin
      os_cnt_r <= os_cnt_r + OS_W'(1);
    end
  end

  // Data bits arrive LSB first, so each decision enters at the top.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r <= 8'h00;
    end else if ((state_r == ST_DATA) && decide_s) begin
      shift_r <= {bit_val_s, shift_r[7:1]};
    end else begin
      shift_r <= shift_r;
    end
  end

  // Registered outputs; pulses land together with the return to idle.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_r   <= 8'h00;
      rx_done_r   <= 1'b0;
      frame_err_r <= 1'b0;
      rx_state_r  <= 1'b0;
    end else begin
      rx_data_r   <= done_s ? shift_r : rx_data_r;
      rx_done_r   <= done_s;
      frame_err_r <= ferr_s;
      rx_state_r  <= (state_s != ST_IDLE);
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_done   = rx_done_r;
  assign frame_err = frame_err_r;
  assign rx_state  = rx_state_r;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomised self-checking bench for uart_byte_rx; a behavioural serial
// transmitter drives the line and an expected-event queue models the receiver.
module tb_uart_byte_rx;

  localparam int NOM_BIT = 8681;  // one bit at 115200 baud, in ns (1 time unit = 1 ns notionally)

  logic       sys_clk  = 1'b0;
  logic       reset_n  = 1'b0;
  logic       rs232_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_state;
  logic       frame_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         exp_rd = 0;
  int         got_rd = 0;
  int         exp_ferr = 0;
  int         got_ferr = 0;
  int         both_cnt = 0;
  int         long_cnt = 0;
  int         busy_cnt = 0;
  logic       prev_done = 1'b0;
  logic [7:0] last_good = 8'h00;

  always #10 sys_clk = ~sys_clk;

  uart_byte_rx #(.CLK_FREQ(50000000), .BAUD_RATE(115200)) dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .rs232_rx  (rs232_rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_state  (rx_state),
    .frame_err (frame_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge away from the active edge.
  always @(negedge sys_clk) begin
    if (rx_done) got_q.push_back(rx_data);
    if (frame_err) got_ferr++;
    if (rx_done && frame_err) both_cnt++;
    if (rx_done && prev_done) long_cnt++;
    if (rx_state) busy_cnt++;
    prev_done = rx_done;
  end

  // Serial transmitter: start, 8 data LSB first, stop; optional 1/16-bit low spike.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int bit_u, input int spike_bit);
    logic [9:0] frame;
    frame = {stop_val, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rs232_rx = frame[i];
      if (i == spike_bit) begin
        #((bit_u * 7) / 16);
        rs232_rx = 1'b0;
        #(bit_u / 16);
        rs232_rx = frame[i];
        #(bit_u - (bit_u * 7) / 16 - bit_u / 16);
      end else begin
        #(bit_u);
      end
    end
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
    last_good = b;
  endtask

  // Compares every received byte and framing-error count against the model so far.
  task automatic verify(input string tag);
    #2000;
    while (exp_rd < exp_q.size() && got_rd < got_q.size()) begin
      check_eq({tag, "_byte"}, {24'h0, got_q[got_rd]}, {24'h0, exp_q[exp_rd]});
      exp_rd++;
      got_rd++;
    end
    check_eq({tag, "_count"}, got_q.size() - got_rd, exp_q.size() - exp_rd);
    exp_rd = exp_q.size();
    got_rd = got_q.size();
    check_eq({tag, "_ferr"}, got_ferr, exp_ferr);
    check_eq({tag, "_idle"}, {31'h0, rx_state}, 32'h0);
  endtask

  function automatic int bit_units(input int permille);
    return int'(1.0e12 / (115200.0 * real'(permille)));
  endfunction

  initial begin
    int busy_base;
    logic [7:0] lb_bytes [4];
    lb_bytes[0] = 8'hC2;
    lb_bytes[1] = 8'hB3;
    lb_bytes[2] = 8'hA4;
    lb_bytes[3] = 8'h95;

    #95;
    @(negedge sys_clk);
    check_eq("rst_data", {24'h0, rx_data}, 32'h0);
    check_eq("rst_done", {31'h0, rx_done}, 32'h0);
    check_eq("rst_state", {31'h0, rx_state}, 32'h0);
    check_eq("rst_ferr", {31'h0, frame_err}, 32'h0);
    reset_n = 1'b1;
    #2000;

    // Back-to-back loopback frames.
    for (int i = 0; i < 4; i++) begin
      send_frame(lb_bytes[i], 1'b1, NOM_BIT, -1);
      expect_byte(lb_bytes[i]);
    end
    verify("loopback");
    check_eq("loopback_last", {24'h0, rx_data}, 32'h95);

    // Start glitch shorter than half a bit.
    busy_base = busy_cnt;
    rs232_rx = 1'b0;
    #4000;
    rs232_rx = 1'b1;
    #(NOM_BIT * 2);
    check_eq("glitch_busy", {31'h0, busy_cnt > busy_base}, 32'h1);
    verify("glitch");

    // Low spike inside data bit 2 (a one) must be voted out.
    send_frame(8'h55, 1'b1, NOM_BIT, 3);
    expect_byte(8'h55);
    verify("noise");

    // Stop bit low, then line held in break.
    send_frame(8'h3C, 1'b0, NOM_BIT, -1);
    exp_ferr++;
    #(NOM_BIT * 4);
    verify("framing");
    check_eq("ferr_hold", {24'h0, rx_data}, {24'h0, last_good});
    rs232_rx = 1'b1;
    #(NOM_BIT);
    verify("break");

    // Reset during data bit 4 discards the partial frame.
    fork
      send_frame(8'hF0, 1'b1, NOM_BIT, -1);
      begin
        #(NOM_BIT * 5 + NOM_BIT / 2);
        reset_n = 1'b0;
        #100;
        check_eq("midrst_data", {24'h0, rx_data}, 32'h0);
        check_eq("midrst_state", {31'h0, rx_state}, 32'h0);
        reset_n = 1'b1;
      end
    join
    last_good = 8'h00;
    send_frame(8'h0F, 1'b1, NOM_BIT, -1);
    expect_byte(8'h0F);
    verify("after_reset");
    check_eq("after_reset_data", {24'h0, rx_data}, 32'h0F);

    // Transmitter 2% fast and 2% slow.
    send_frame(8'hA5, 1'b1, bit_units(1020), -1);
    expect_byte(8'hA5);
    verify("fast");
    check_eq("fast_data", {24'h0, rx_data}, 32'hA5);
    send_frame(8'hA5, 1'b1, bit_units(980), -1);
    expect_byte(8'hA5);
    verify("slow");
    check_eq("slow_data", {24'h0, rx_data}, 32'hA5);

    // Random bytes at random rate within tolerance and random idle gaps.
    for (int i = 0; i < 3; i++) begin
      logic [7:0] rb;
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1, bit_units(int'($urandom_range(980, 1020))), -1);
      expect_byte(rb);
      #($urandom_range(0, 5000));
    end
    verify("random");

    check_eq("exclusive_pulses", both_cnt, 0);
    check_eq("done_one_cycle", long_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
